// File: rtl/release_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : release_scheduler
// Purpose  : Sequences the draining of response_memory toward the outgoing
//            response path. A linked list per original AXI ID keeps UIDs in
//            issue order. Original IDs whose oldest UID has a fully stored
//            burst are arbitrated round robin. The granted burst is popped
//            beat by beat, and the allocator is then asked to free the UID.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            enq_valid/enq_ready/
//            enq_orig_id/enq_uid           - AR accepted with granted UID
//            done_valid/done_uid           - burst for a UID fully stored
//            rm_free_req/rm_uid_to_free/
//            rm_free_ack/rm_last           - beat pop handshake to response_memory
//            alloc_free_req/
//            alloc_uid_to_free             - one-cycle free request to allocator
//            busy                          - FSM not idle
//            err_overrun                   - sticky burst-overrun / stray-done flag
// Revision : 1.0 - initial release
// ============================================================================
module release_scheduler #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int MAX_LEN         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [ID_WIDTH-1:0] enq_orig_id,
  input  logic [ID_WIDTH-1:0] enq_uid,
  input  logic                done_valid,
  input  logic [ID_WIDTH-1:0] done_uid,
  output logic                rm_free_req,
  output logic [ID_WIDTH-1:0] rm_uid_to_free,
  input  logic                rm_free_ack,
  input  logic                rm_last,
  output logic                alloc_free_req,
  output logic [ID_WIDTH-1:0] alloc_uid_to_free,
  output logic                busy,
  output logic                err_overrun
);

  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W  = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RETIRE = 2'd2
  } state_t;

  // Per original ID list pointers
  logic [ID_WIDTH-1:0] head_q [NUM_IDS];
  logic [ID_WIDTH-1:0] head_d [NUM_IDS];
  logic [ID_WIDTH-1:0] tail_q [NUM_IDS];
  logic [ID_WIDTH-1:0] tail_d [NUM_IDS];
  logic [NUM_IDS-1:0]  nonempty_q, nonempty_d;

  // Per UID link and status
  logic [ID_WIDTH-1:0] next_q [NUM_IDS];
  logic [ID_WIDTH-1:0] next_d [NUM_IDS];
  logic [NUM_IDS-1:0]  tracked_q, tracked_d;
  logic [NUM_IDS-1:0]  done_q, done_d;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [ID_WIDTH-1:0] cur_uid_q, cur_uid_d;
  logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                rm_free_req_q, rm_free_req_d;
  logic                alloc_free_req_q, alloc_free_req_d;
  logic                busy_q, busy_d;

  logic                enq_fire;
  logic                retire_fire;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] cand;

  assign enq_ready   = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign enq_fire    = enq_valid & enq_ready;
  assign retire_fire = (state_q == ST_RETIRE);

  assign rm_free_req       = rm_free_req_q;
  assign rm_uid_to_free    = cur_uid_q;
  assign alloc_free_req    = alloc_free_req_q;
  assign alloc_uid_to_free = cur_uid_q;
  assign busy              = busy_q;
  assign err_overrun       = err_q;

  // Round-robin search: first eligible ID at or above rr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      cand = rr_q + ID_WIDTH'(i);
      if (!grant_found && nonempty_q[cand] && done_q[head_q[cand]]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    nonempty_d = nonempty_q;
    next_d     = next_q;
    tracked_d  = tracked_q;
    done_d     = done_q;
    state_d    = state_q;
    rr_d       = rr_q;
    cur_uid_d  = cur_uid_q;
    cur_id_d   = cur_id_q;
    beat_d     = beat_q;
    err_d      = err_q;
    count_d    = count_q;

    // Completion notices; a notice for a UID nobody is waiting on is an error.
    if (done_valid) begin
      if (tracked_q[done_uid]) begin
        done_d[done_uid] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d   = ST_DRAIN;
          cur_uid_d = head_q[grant_id];
          cur_id_d  = grant_id;
          rr_d      = grant_id + ID_WIDTH'(1);
          beat_d    = '0;
        end
      end
      ST_DRAIN: begin
        if (rm_free_ack) begin
          beat_d = beat_q + BEAT_W'(1);
          if (rm_last) begin
            state_d = ST_RETIRE;
          end else if (beat_q == BEAT_W'(MAX_LEN)) begin
            // Burst ran past the longest legal length: flag and free it anyway.
            err_d   = 1'b1;
            state_d = ST_RETIRE;
          end
        end
      end
      ST_RETIRE: begin
        // Pop the head; cur_uid is always the head of cur_id's list here.
        if (head_q[cur_id_q] == tail_q[cur_id_q]) begin
          nonempty_d[cur_id_q] = 1'b0;
        end else begin
          head_d[cur_id_q] = next_q[head_q[cur_id_q]];
        end
        // Clear after the done update above so a same-cycle notice loses.
        tracked_d[cur_uid_q] = 1'b0;
        done_d[cur_uid_q]    = 1'b0;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Push after the pop so a same-ID enqueue sees the post-pop list.
    if (enq_fire) begin
      if (nonempty_d[enq_orig_id]) begin
        next_d[tail_d[enq_orig_id]] = enq_uid;
        tail_d[enq_orig_id]         = enq_uid;
      end else begin
        head_d[enq_orig_id]     = enq_uid;
        tail_d[enq_orig_id]     = enq_uid;
        nonempty_d[enq_orig_id] = 1'b1;
      end
      tracked_d[enq_uid] = 1'b1;
      done_d[enq_uid]    = 1'b0;
    end

    if (enq_fire && !retire_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq_fire && retire_fire) begin
      count_d = count_q - CNT_W'(1);
    end

    rm_free_req_d    = (state_d == ST_DRAIN);
    alloc_free_req_d = (state_d == ST_RETIRE);
    busy_d           = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_IDS; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        next_q[k] <= '0;
      end
      nonempty_q       <= '0;
      tracked_q        <= '0;
      done_q           <= '0;
      state_q          <= ST_IDLE;
      rr_q             <= '0;
      cur_uid_q        <= '0;
      cur_id_q         <= '0;
      beat_q           <= '0;
      count_q          <= '0;
      err_q            <= 1'b0;
      rm_free_req_q    <= 1'b0;
      alloc_free_req_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      next_q           <= next_d;
      nonempty_q       <= nonempty_d;
      tracked_q        <= tracked_d;
      done_q           <= done_d;
      state_q          <= state_d;
      rr_q             <= rr_d;
      cur_uid_q        <= cur_uid_d;
      cur_id_q         <= cur_id_d;
      beat_q           <= beat_d;
      count_q          <= count_d;
      err_q            <= err_d;
      rm_free_req_q    <= rm_free_req_d;
      alloc_free_req_q <= alloc_free_req_d;
      busy_q           <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_release_scheduler
// Purpose  : Directed, table-driven bench for release_scheduler, plus
//            hand-written sequences for arbitration, back-pressure, overrun
//            and reset-in-burst corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_release_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enq_valid;
  logic       enq_ready;
  logic [3:0] enq_orig_id;
  logic [3:0] enq_uid;
  logic       done_valid;
  logic [3:0] done_uid;
  logic       rm_free_req;
  logic [3:0] rm_uid_to_free;
  logic       rm_free_ack;
  logic       rm_last;
  logic       alloc_free_req;
  logic [3:0] alloc_uid_to_free;
  logic       busy;
  logic       err_overrun;

  always #5 clk = ~clk;

  release_scheduler #(
    .ID_WIDTH(4),
    .MAX_OUTSTANDING(16),
    .MAX_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_orig_id(enq_orig_id),
    .enq_uid(enq_uid),
    .done_valid(done_valid),
    .done_uid(done_uid),
    .rm_free_req(rm_free_req),
    .rm_uid_to_free(rm_uid_to_free),
    .rm_free_ack(rm_free_ack),
    .rm_last(rm_last),
    .alloc_free_req(alloc_free_req),
    .alloc_uid_to_free(alloc_uid_to_free),
    .busy(busy),
    .err_overrun(err_overrun)
  );

  typedef struct {
    bit       ev;
    bit [3:0] eo;
    bit [3:0] eu;
    bit       dv;
    bit [3:0] du;
    bit       ak;
    bit       lt;
    bit       x_rdy;
    bit       x_rm;
    bit [3:0] x_rmuid;
    bit       x_al;
    bit [3:0] x_aluid;
    bit       x_busy;
    bit       x_err;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enq_valid   = 1'b0;
    enq_orig_id = '0;
    enq_uid     = '0;
    done_valid  = 1'b0;
    done_uid    = '0;
    rm_free_ack = 1'b0;
    rm_last     = 1'b0;
  endtask

  task automatic add(input bit ev, input bit [3:0] eo, input bit [3:0] eu,
                     input bit dv, input bit [3:0] du, input bit ak, input bit lt,
                     input bit x_rdy, input bit x_rm, input bit [3:0] x_rmuid,
                     input bit x_al, input bit [3:0] x_aluid, input bit x_busy,
                     input bit x_err);
    vec_t v;
    v.ev = ev; v.eo = eo; v.eu = eu; v.dv = dv; v.du = du; v.ak = ak; v.lt = lt;
    v.x_rdy = x_rdy; v.x_rm = x_rm; v.x_rmuid = x_rmuid; v.x_al = x_al;
    v.x_aluid = x_aluid; v.x_busy = x_busy; v.x_err = x_err;
    vecs.push_back(v);
  endtask

  task automatic enq(input int o, input int u);
    enq_valid   = 1'b1;
    enq_orig_id = 4'(o);
    enq_uid     = 4'(u);
    step();
    enq_valid   = 1'b0;
  endtask

  task automatic done(input int u);
    done_valid = 1'b1;
    done_uid   = 4'(u);
    step();
    done_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a drain to start, pop `beats` beats, then confirm the
  // free pulse. Returns in the RETIRE cycle.
  task automatic expect_burst(input string name, input int uid, input int beats);
    int n = 0;
    while (rm_free_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({name, " rm_free_req"}, int'(rm_free_req === 1'b1), 1);
    chk({name, " rm_uid"}, int'(rm_uid_to_free), uid);
    for (int b = 0; b < beats; b++) begin
      rm_free_ack = 1'b1;
      rm_last     = (b == beats - 1);
      step();
    end
    rm_free_ack = 1'b0;
    rm_last     = 1'b0;
    chk({name, " alloc_free_req"}, int'(alloc_free_req), 1);
    chk({name, " alloc_uid"}, int'(alloc_uid_to_free), uid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    chk("reset enq_ready", int'(enq_ready), 1);
    chk("reset rm_free_req", int'(rm_free_req), 0);
    chk("reset rm_uid", int'(rm_uid_to_free), 0);
    chk("reset alloc_free_req", int'(alloc_free_req), 0);
    chk("reset alloc_uid", int'(alloc_uid_to_free), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset err", int'(err_overrun), 0);
    rst = 1'b0;

    // Single 4-beat burst: orig 3 / uid 5.
    //   ev eo eu  dv du ak lt   rdy rm uid al uid busy err
    add(1, 3, 5,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  1, 5, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 1, 0,   1,  1, 5,  0, 0,  1,   0);
    add(0, 0, 0,  0, 0, 1, 0,   1,  1, 5,  0, 0,  1,   0);
    add(0, 0, 0,  0, 0, 1, 0,   1,  1, 5,  0, 0,  1,   0);
    add(0, 0, 0,  0, 0, 1, 1,   1,  1, 5,  0, 0,  1,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  1, 5,  1,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    // Order within one original ID: uid 1 then uid 7; done for 7 first.
    add(1, 2, 1,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(1, 2, 7,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  1, 7, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  1, 1, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 1, 1,   1,  1, 1,  0, 0,  1,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  1, 1,  1,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);
    add(0, 0, 0,  0, 0, 1, 1,   1,  1, 7,  0, 0,  1,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  1, 7,  1,   0);
    add(0, 0, 0,  0, 0, 0, 0,   1,  0, 0,  0, 0,  0,   0);

    foreach (vecs[i]) begin
      enq_valid   = vecs[i].ev;
      enq_orig_id = vecs[i].eo;
      enq_uid     = vecs[i].eu;
      done_valid  = vecs[i].dv;
      done_uid    = vecs[i].du;
      rm_free_ack = vecs[i].ak;
      rm_last     = vecs[i].lt;
      chk($sformatf("v%0d enq_ready", i), int'(enq_ready), int'(vecs[i].x_rdy));
      chk($sformatf("v%0d rm_free_req", i), int'(rm_free_req), int'(vecs[i].x_rm));
      if (vecs[i].x_rm)
        chk($sformatf("v%0d rm_uid", i), int'(rm_uid_to_free), int'(vecs[i].x_rmuid));
      chk($sformatf("v%0d alloc_free_req", i), int'(alloc_free_req), int'(vecs[i].x_al));
      if (vecs[i].x_al)
        chk($sformatf("v%0d alloc_uid", i), int'(alloc_uid_to_free), int'(vecs[i].x_aluid));
      chk($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].x_busy));
      chk($sformatf("v%0d err", i), int'(err_overrun), int'(vecs[i].x_err));
      step();
    end
    clear_inputs();

    // Round robin: hold the FSM on ID 15 while 0, 4 and 9 all become ready.
    enq(15, 15);
    enq(0, 0);
    enq(4, 4);
    enq(9, 9);
    done(15);
    step();
    done(0);
    done(4);
    done(9);
    expect_burst("rr id15", 15, 1);
    expect_burst("rr id0", 0, 1);
    // Re-enqueue ID 0 in its own RETIRE cycle (pop then push), then mark done.
    enq(0, 0);
    done(0);
    expect_burst("rr id4", 4, 1);
    expect_burst("rr id9", 9, 1);
    expect_burst("rr id0 again", 0, 1);
    step();
    chk("rr busy after", int'(busy), 0);

    // Back-pressure: fill all 16 slots, then retire one while an enqueue waits.
    for (int i = 0; i < 16; i++) enq(i, i);
    chk("full enq_ready", int'(enq_ready), 0);
    done(0);
    expect_burst("full drain0", 0, 1);
    enq_valid   = 1'b1;
    enq_orig_id = 4'd5;
    enq_uid     = 4'd0;
    chk("full retire enq_ready", int'(enq_ready), 0);
    step();
    chk("full after retire enq_ready", int'(enq_ready), 1);
    step();
    enq_valid = 1'b0;
    chk("full refilled enq_ready", int'(enq_ready), 0);

    // Overrun: no rm_last; 8 beats are legal, the 9th trips the error.
    do_reset();
    enq(1, 3);
    done(3);
    step();
    chk("ovr drain start", int'(rm_free_req), 1);
    for (int b = 0; b < 8; b++) begin
      rm_free_ack = 1'b1;
      step();
    end
    chk("ovr err after 8", int'(err_overrun), 0);
    chk("ovr still draining", int'(rm_free_req), 1);
    step();
    rm_free_ack = 1'b0;
    chk("ovr err", int'(err_overrun), 1);
    chk("ovr alloc_free_req", int'(alloc_free_req), 1);
    chk("ovr alloc_uid", int'(alloc_uid_to_free), 3);
    step();
    chk("ovr err sticky", int'(err_overrun), 1);
    chk("ovr busy", int'(busy), 0);
    chk("ovr alloc pulse ends", int'(alloc_free_req), 0);

    // Done for an untracked UID.
    do_reset();
    chk("stray err before", int'(err_overrun), 0);
    done(12);
    chk("stray err", int'(err_overrun), 1);
    step();
    step();
    chk("stray no drain", int'(rm_free_req), 0);
    chk("stray busy", int'(busy), 0);

    // Reset in the middle of a burst.
    do_reset();
    enq(2, 6);
    done(6);
    step();
    chk("rst drain start", int'(rm_free_req), 1);
    rm_free_ack = 1'b1;
    step();
    step();
    rm_free_ack = 1'b0;
    rst = 1'b1;
    step();
    chk("rst rm_free_req", int'(rm_free_req), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst enq_ready", int'(enq_ready), 1);
    chk("rst alloc_free_req", int'(alloc_free_req), 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst after c%0d alloc", c), int'(alloc_free_req), 0);
      chk($sformatf("rst after c%0d rm", c), int'(rm_free_req), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
